fft_ram_arbiter: RTL and testbench

Arbiter for read port B of the 128×32 FFT sample RAM (`dual_sram`), shared between two read requesters: requester 0 is `fft_read_ram` and requester 1 is the host/debug readback path. It sits between the requesters and the RAM port and grants whole bursts round-robin. It multiplexes address and enable into the RAM and routes each read response back to the requester that issued it, using the RAM's 1-cycle read latency.

---
 rtl/fft_ram_arbiter_pkg.sv | 27 ++
 rtl/fft_ram_arbiter_if.sv | 32 +++
 rtl/fft_ram_arbiter_rr.sv | 100 ++++++++++
 rtl/fft_ram_arbiter.sv | 80 ++++++++
 tb/tb_fft_ram_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/fft_ram_arbiter_pkg.sv
// Shared definitions for the FFT sample RAM port-B read arbiter.
// Holds the arbiter state encoding, RAM geometry and requester indices.
package fft_ram_pkg;

  localparam int RAM_AWIDTH = 7;
  localparam int RAM_DWIDTH = 32;

  // Requester 0 is the FFT engine reader, requester 1 the host/debug path.
  localparam int REQ_FFT  = 0;
  localparam int REQ_HOST = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // One-hot grant vector that corresponds to an arbiter state.
  function automatic logic [1:0] state_gnt(input arb_state_t s);
    logic [1:0] g;
    g = 2'b00;
    if (s == OWN0) g[REQ_FFT] = 1'b1;
    if (s == OWN1) g[REQ_HOST] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/fft_ram_arbiter_if.sv
// Requester/RAM-side bundle of the port-B read arbiter.
// slave = arbiter view, master = requesters plus RAM data return.
interface fft_ram_arbiter_if
  import fft_ram_pkg::*;
#(
  parameter int DWIDTH = RAM_DWIDTH,
  parameter int AWIDTH = RAM_AWIDTH
);

  logic [1:0]        req_in;
  logic [1:0]        rd_in;
  logic [AWIDTH-1:0] addr0_in;
  logic [AWIDTH-1:0] addr1_in;
  logic [1:0]        gnt_out;
  logic              ram_en_out;
  logic [AWIDTH-1:0] ram_addr_out;
  logic [DWIDTH-1:0] ram_data_in;
  logic [DWIDTH-1:0] rd_data_out;
  logic [1:0]        rd_valid_out;
  logic              err_out;

  modport slave (
    input  req_in, rd_in, addr0_in, addr1_in, ram_data_in,
    output gnt_out, ram_en_out, ram_addr_out, rd_data_out, rd_valid_out, err_out
  );

  modport master (
    output req_in, rd_in, addr0_in, addr1_in, ram_data_in,
    input  gnt_out, ram_en_out, ram_addr_out, rd_data_out, rd_valid_out, err_out
  );

endinterface

// File: rtl/fft_ram_arbiter_rr.sv
// fft_arb_rr: round-robin burst grant FSM with last-served memory.
// Optional macro FFT_ARB_BURST_LIMIT_EN adds a burst counter that forces
// handoff to a waiting requester after MAX_BURST accepted reads.
module fft_arb_rr
  import fft_ram_pkg::*;
#(
  parameter int AWIDTH    = RAM_AWIDTH,
  parameter int MAX_BURST = 16
) (
  input  logic       clk,
  input  logic       srst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  arb_state_t state_reg, state_next;
  logic       last_reg, last_next;
  logic [1:0] gnt_reg;
  logic       limit_hit;

`ifdef FFT_ARB_BURST_LIMIT_EN
  localparam int CW = AWIDTH + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;

  // Saturating count of reads accepted in the current grant, including this cycle.
  always_comb begin
    cnt_inc = cnt_reg;
    if (accept && (cnt_reg < MAX_CNT)) cnt_inc = cnt_reg + 1'b1;
    limit_hit = (cnt_inc >= MAX_CNT);
    cnt_next  = cnt_inc;
    if (limit_hit || (state_next != state_reg)) cnt_next = '0;
  end

  // Burst counter register.
  always_ff @(posedge clk) begin
    if (srst) cnt_reg <= '0;
    else      cnt_reg <= cnt_next;
  end
`else
  logic unused_cfg;

  // Without the limit the owner keeps the port until it drops its request.
  assign limit_hit  = 1'b0;
  assign unused_cfg = accept ^ (MAX_BURST != 0) ^ (AWIDTH != 0);
`endif

  // Next state and last-served update; ties in IDLE go to the one not served last.
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        case (req)
          2'b01:   state_next = OWN0;
          2'b10:   state_next = OWN1;
          2'b11:   state_next = last_reg ? OWN0 : OWN1;
          default: state_next = IDLE;
        endcase
      end
      OWN0: begin
        if (!req[0]) begin
          last_next  = 1'b0;
          state_next = req[1] ? OWN1 : IDLE;
        end else if (limit_hit && req[1]) begin
          last_next  = 1'b0;
          state_next = OWN1;
        end
      end
      OWN1: begin
        if (!req[1]) begin
          last_next  = 1'b1;
          state_next = req[0] ? OWN0 : IDLE;
        end else if (limit_hit && req[0]) begin
          last_next  = 1'b1;
          state_next = OWN0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, last-served flag and registered one-hot grant.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      gnt_reg   <= 2'b00;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      gnt_reg   <= state_gnt(state_next);
    end
  end

  assign gnt = gnt_reg;

endmodule

// File: rtl/fft_ram_arbiter.sv
// fft_ram_arbiter: shares read port B of the 128x32 FFT sample RAM between
// the FFT reader (requester 0) and the host readback path (requester 1).
// Grants whole bursts round-robin, muxes address/enable into the RAM and
// routes each 1-cycle-latency response to the requester that issued it.
// Optional macro FFT_ARB_BURST_LIMIT_EN enables the MAX_BURST forced handoff.
module fft_ram_arbiter
  import fft_ram_pkg::*;
#(
  parameter int DWIDTH    = RAM_DWIDTH,
  parameter int AWIDTH    = RAM_AWIDTH,
  parameter int MAX_BURST = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  fft_ram_arbiter_if.slave  bus
);

  logic [1:0]        gnt;
  logic [1:0]        acc;
  logic [1:0]        stray;
  logic [1:0]        rd_valid;
  logic              accept;
  logic [AWIDTH-1:0] addr_mux;
  logic [AWIDTH-1:0] addr_hold_reg;
  logic              valid_reg;
  logic              tag_reg;
  logic              err_reg;

  fft_arb_rr #(
    .AWIDTH    (AWIDTH),
    .MAX_BURST (MAX_BURST)
  ) u_rr (
    .clk    (clk_in),
    .srst   (rst_in),
    .req    (bus.req_in),
    .accept (accept),
    .gnt    (gnt)
  );

  // Per-requester read acceptance, dropped strobes and response valids.
  // The response valid is squashed while reset is asserted so that an
  // in-flight read never surfaces across a reset.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign acc[gi]      = bus.rd_in[gi] & gnt[gi] & bus.req_in[gi];
    assign stray[gi]    = bus.rd_in[gi] & ~gnt[gi];
    assign rd_valid[gi] = valid_reg & (tag_reg == 1'(gi)) & ~rst_in;
  end

  assign accept = |acc;

  // Owner's address, holding the last driven value while nobody owns the port.
  always_comb begin
    addr_mux = addr_hold_reg;
    if (gnt[REQ_FFT])       addr_mux = bus.addr0_in;
    else if (gnt[REQ_HOST]) addr_mux = bus.addr1_in;
  end

  // Address hold, response tag pipeline and sticky error flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_hold_reg <= '0;
      valid_reg     <= 1'b0;
      tag_reg       <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      if (|gnt) addr_hold_reg <= addr_mux;
      valid_reg <= accept;
      if (accept) tag_reg <= gnt[REQ_HOST];
      if (|stray) err_reg <= 1'b1;
    end
  end

  assign bus.gnt_out      = gnt;
  assign bus.ram_en_out   = accept;
  assign bus.ram_addr_out = addr_mux;
  assign bus.rd_data_out  = bus.ram_data_in;
  assign bus.rd_valid_out = rd_valid;
  assign bus.err_out      = err_reg;

endmodule

// File: tb/tb_fft_ram_arbiter.sv
// Bench for fft_ram_arbiter: directed scenarios plus randomized request
// traffic, compared each cycle with a behavioural arbitration model.
module tb_fft_ram_arbiter;
  import fft_ram_pkg::*;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_ram_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  fft_ram_arbiter #(
    .DWIDTH    (DW),
    .AWIDTH    (AW),
    .MAX_BURST (MB)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  // RAM port B: one-cycle registered read.
  logic [DW-1:0] mem [128];
  logic [DW-1:0] ram_q;
  always @(posedge clk) if (bus.ram_en_out) ram_q <= mem[bus.ram_addr_out];
  assign bus.ram_data_in = ram_q;

  // Reference model state
  int            owner;   // -1: nobody owns the port
  int            last;
  int            cnt;
  logic          err_m;
  logic          pend_v;
  int            pend_who;
  logic [DW-1:0] pend_d;
  logic [AW-1:0] hold;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; last = 1; cnt = 0; err_m = 1'b0;
    pend_v = 1'b0; pend_who = 0; pend_d = '0; hold = '0;
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic cycle(input logic r, input logic [1:0] rq, input logic [1:0] rdv,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    logic [1:0]    exp_gnt;
    logic [1:0]    exp_vld;
    logic          acc;
    logic [AW-1:0] own_addr;
    int            x, y;
    @(negedge clk);
    rst = r;
    bus.req_in = rq; bus.rd_in = rdv; bus.addr0_in = a0; bus.addr1_in = a1;
    #1;
    exp_gnt  = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
    acc      = (owner >= 0) && rdv[owner] && rq[owner];
    own_addr = (owner == 1) ? a1 : a0;
    exp_vld  = (r || !pend_v) ? 2'b00 : ((pend_who == 1) ? 2'b10 : 2'b01);
    check_eq("gnt", bus.gnt_out, exp_gnt);
    check_eq("ram_en", bus.ram_en_out, acc);
    check_eq("ram_addr", bus.ram_addr_out, (owner < 0) ? hold : own_addr);
    check_eq("err", bus.err_out, err_m);
    check_eq("rd_valid", bus.rd_valid_out, exp_vld);
    if (exp_vld != 2'b00) begin
      check_eq("rd_data", bus.rd_data_out, pend_d);
      $display("rsp: requester %0d data %08h", pend_who, pend_d);
    end
    if (r) begin
      model_reset();
    end else begin
      if ((rdv & ~exp_gnt) != 2'b00) err_m = 1'b1;
      pend_v   = acc;
      pend_who = owner;
      pend_d   = mem[own_addr];
      if (owner >= 0) hold = own_addr;
      if (owner < 0) begin
        if (rq == 2'b01)      owner = 0;
        else if (rq == 2'b10) owner = 1;
        else if (rq == 2'b11) owner = (last == 1) ? 0 : 1;
      end else begin
        x = owner; y = 1 - owner;
        if (!rq[x]) begin
          last = x; cnt = 0;
          owner = rq[y] ? y : -1;
        end else begin
`ifdef FFT_ARB_BURST_LIMIT_EN
          if (acc) cnt++;
          if (cnt >= MB) begin
            cnt = 0;
            if (rq[y]) begin last = x; owner = y; end
          end
`endif
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 2'b00, '0, '0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 2'b00, 2'b00, '0, '0);
  endtask

  initial begin
    logic [1:0] rq;
    logic [1:0] rdv;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    bus.req_in = '0; bus.rd_in = '0; bus.addr0_in = '0; bus.addr1_in = '0;
    model_reset();

    // Reset state
    do_reset();
    do_reset();

    // Single requester, 8 reads at addresses 0..7
    cycle(1'b0, 2'b01, 2'b00, '0, '0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 2'b01, 2'b01, AW'(i), AW'($urandom));
    idle_cycles(3);

    // Simultaneous request from reset, handoff with no bubble, later tie
    do_reset();
    cycle(1'b0, 2'b11, 2'b00, '0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'b11, 2'b11, AW'($urandom), AW'($urandom));
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'b10, 2'b10, AW'($urandom), AW'($urandom));
    idle_cycles(2);
    cycle(1'b0, 2'b11, 2'b00, '0, '0);
    cycle(1'b0, 2'b11, 2'b01, AW'(9), AW'(3));
    idle_cycles(2);

    // Ungranted strobe from requester 1 while requester 0 owns the port
    cycle(1'b0, 2'b01, 2'b00, '0, '0);
    cycle(1'b0, 2'b01, 2'b10, AW'(20), AW'(40));
    cycle(1'b0, 2'b01, 2'b01, AW'(21), AW'(41));
    idle_cycles(3);
    do_reset();

    // Both requesters streaming continuously
    for (int i = 0; i < 24; i++) cycle(1'b0, 2'b11, 2'b11, AW'($urandom), AW'($urandom));
    idle_cycles(2);

    // Reset the cycle after a read
    cycle(1'b0, 2'b01, 2'b00, '0, '0);
    cycle(1'b0, 2'b01, 2'b01, AW'(5), AW'(0));
    do_reset();
    idle_cycles(1);
    cycle(1'b0, 2'b10, 2'b00, '0, '0);
    cycle(1'b0, 2'b10, 2'b10, AW'(0), AW'(77));
    idle_cycles(2);

    // Randomized burst traffic
    do_reset();
    rq = 2'b00;
    for (int i = 0; i < 600; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (rq[j]) rq[j] = ($urandom_range(0, 7) != 0);
        else       rq[j] = ($urandom_range(0, 3) == 0);
        rdv[j] = (rq[j] && $urandom_range(0, 1) == 1) || ($urandom_range(0, 99) == 0);
      end
      cycle(1'b0, rq, rdv, AW'($urandom), AW'($urandom));
    end
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
